mul_iter: RTL and testbench
===========================

Name: mul_iter

Overview:
Parametrised iterative multiplier for the CPU's HI/LO multiply path. It replaces the single-cycle combinational multiplier with a multi-cycle shift-add engine that has a start/busy/done handshake. It supports signed and unsigned operands, multiply-accumulate (MADD/MADDU) into the held result, and cancel on pipeline flush. The execute stage stalls on busy and latches z when done pulses.

Parameters:
WIDTH, 32, operand width; z is 2*WIDTH bits.
BITS_PER_CYCLE, 1, multiplier bits retired per RUN cycle; legal values 1, 2, 4; must divide WIDTH.

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-low reset
start  input  1  request a new operation; sampled only in IDLE
is_signed  input  1  1 = treat a and b as two's complement; 0 = unsigned
acc_en  input  1  1 = add the product to the current z (MADD); 0 = overwrite z
cancel  input  1  abort the in-flight operation (pipeline flush)
a  input  WIDTH  multiplicand
b  input  WIDTH  multiplier
busy  output  1  operation in progress (RUN or FINISH)
done  output  1  one-cycle pulse when z has been updated
z  output  2*WIDTH  result register (HI = upper WIDTH bits, LO = lower)

Behaviour:
- Reset (reset=0 at a clock edge): state=IDLE, z=0, busy=0, done=0, and all internal registers cleared. Reset overrides every other input.
- Let N = WIDTH/BITS_PER_CYCLE. States are IDLE, RUN and FINISH.
- IDLE: at an edge where start=1 and cancel=0, the block latches:
  - mag_a and mag_b: the magnitudes of a and b when is_signed=1 (negate if the MSB is 1), otherwise the raw values;
  - neg = is_signed & (a[MSB]^b[MSB]);
  - acc_en;
  - count = N;
  - partial = 0.
  It then sets busy=1 and goes to RUN.
- The magnitude of the most-negative value (e.g. 0x80000000) is taken as the unsigned WIDTH-bit value 2^(WIDTH-1). No overflow case exists.
- RUN, on each edge:
  - partial += (mag_a * low BITS_PER_CYCLE bits of the multiplier) << shift;
  - the multiplier shifts right by BITS_PER_CYCLE;
  - count decrements.
  - When count reaches 0, go to FINISH. RUN therefore lasts exactly N cycles.
  - An implementation may instead shift the partial product; only the final result and timing are specified.
- FINISH, on its edge:
  - prod = neg ? -partial : partial, computed mod 2^(2*WIDTH);
  - z = acc_en ? z + prod : prod, with wrap-around mod 2^(2*WIDTH) and no saturation;
  - done=1 for this cycle only, busy=0, state=IDLE.
- Latency: start is sampled at edge E0; z and done become valid after edge E(N+1). With WIDTH=32 and BITS_PER_CYCLE=1 this is 33 cycles; with BITS_PER_CYCLE=4 it is 9 cycles.
- Back-to-back operation: start may be high in the cycle in which done=1, since the state is IDLE then. It is accepted at the next edge, and done drops.
- start while busy=1: ignored and not queued. a, b, is_signed and acc_en may change freely after E0.
- cancel:
  - when busy=1, cancel=1 at an edge sends the block to IDLE with busy=0 and no done pulse. z is unchanged.
  - when in IDLE, cancel together with start means start is ignored.
  - cancel has priority over the FINISH write.
- z holds its value between completions. Outputs are registered, with no combinational path from inputs to outputs.

Test Plan:
1. Signed: is_signed=1, a=7, b=0xFFFFFFFD (-3), acc_en=0 -> done after edge E33, z=0xFFFFFFFF_FFFFFFEB, busy high for exactly 33 cycles.
2. Unsigned: is_signed=0, a=b=0xFFFFFFFF -> z=0xFFFFFFFE_00000001. Then repeat with is_signed=1 -> z=0x00000000_00000001.
3. Corner: is_signed=1, a=b=0x80000000 -> z=0x40000000_00000000. With a=0x80000000, b=1 -> z=0xFFFFFFFF_80000000.
4. Accumulate: run scenario 1, then immediately start again (start high during the done cycle) with a=b=5, is_signed=1, acc_en=1 -> second done 33 cycles later, z=0x00000000_00000004. No idle gap between the two operations.
5. Cancel and start-while-busy: assert start again at cycle 10, which must be ignored, then assert cancel at cycle 20 -> busy falls the next cycle, done never pulses, z keeps its old value. A fresh start afterwards gives the correct result.
6. BITS_PER_CYCLE=4 build: a=0x12345678, b=0x9ABCDEF0, unsigned -> done after edge E9, z=0x0B00EA4E_242D2080. Also assert reset low mid-RUN -> z=0, busy=0, done=0 on the next edge.

Source files
------------

// File: rtl/mul_iter_if.sv
// Start/busy/done handshake bundle for the iterative HI/LO multiplier.
// The master drives operands and control; the slave returns status and the result.
interface mul_iter_if #(
  parameter int WIDTH = 32
);
  logic               start;
  logic               is_signed;
  logic               acc_en;
  logic               cancel;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] z;

  modport master (
    output start, is_signed, acc_en, cancel, a, b,
    input  busy, done, z
  );

  modport slave (
    input  start, is_signed, acc_en, cancel, a, b,
    output busy, done, z
  );
endinterface

// File: rtl/mul_iter.sv
// Multi-cycle shift-add multiplier with signed/unsigned operands,
// multiply-accumulate into the held result and flush cancel.
module mul_iter #(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input logic   clk,
  input logic   reset,
  mul_iter_if.slave bus
);
  localparam int N  = WIDTH / BITS_PER_CYCLE;
  localparam int CW = $clog2(N + 1);
  localparam int ZW = 2 * WIDTH;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FINISH
  } state_t;

  state_t state, state_n;

  logic [ZW-1:0]    mcand;
  logic [ZW-1:0]    partial;
  logic [ZW-1:0]    addend;
  logic [ZW-1:0]    prod;
  logic [ZW-1:0]    z_q;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic [CW-1:0]    count;
  logic             neg;
  logic             acc;
  logic             done_q;
  logic             accept;

  // Most-negative input negates to itself, which read unsigned is 2^(WIDTH-1).
  always_comb begin
    mag_a = bus.a;
    mag_b = bus.b;
    if (bus.is_signed && bus.a[WIDTH-1]) mag_a = -bus.a;
    if (bus.is_signed && bus.b[WIDTH-1]) mag_b = -bus.b;
  end

  assign accept = (state == IDLE) && bus.start && !bus.cancel;

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (accept) state_n = RUN;
      end
      RUN: begin
        if (bus.cancel)               state_n = IDLE;
        else if (count == CW'(1))     state_n = FINISH;
      end
      FINISH: begin
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // One radix-2^BITS_PER_CYCLE digit of the multiplier per RUN cycle.
  always_comb begin
    addend = '0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      if (mplier[i]) addend = addend + (mcand << i);
    end
    prod = neg ? -partial : partial;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      mcand   <= '0;
      mplier  <= '0;
      partial <= '0;
      count   <= '0;
      neg     <= 1'b0;
      acc     <= 1'b0;
      z_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            mcand   <= {{WIDTH{1'b0}}, mag_a};
            mplier  <= mag_b;
            neg     <= bus.is_signed & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            acc     <= bus.acc_en;
            count   <= CW'(N);
            partial <= '0;
          end
        end
        RUN: begin
          if (!bus.cancel) begin
            partial <= partial + addend;
            mcand   <= mcand << BITS_PER_CYCLE;
            mplier  <= mplier >> BITS_PER_CYCLE;
            count   <= count - CW'(1);
          end
        end
        FINISH: begin
          if (!bus.cancel) begin
            z_q    <= acc ? z_q + prod : prod;
            done_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = (state != IDLE);
  assign bus.done = done_q;
  assign bus.z    = z_q;
endmodule

// File: tb/tb_mul_iter.sv
// Directed checks of mul_iter at one and four multiplier bits per cycle.
// Expected values are hand-computed constants.
module tb_mul_iter;
  logic clk;
  logic reset;
  int   checks;
  int   errors;
  int   cyc;
  int   bcnt;
  int   dcnt;

  mul_iter_if #(.WIDTH(32)) b1 ();
  mul_iter_if #(.WIDTH(32)) b4 ();

  mul_iter #(.WIDTH(32), .BITS_PER_CYCLE(1)) u1 (
    .clk   (clk),
    .reset (reset),
    .bus   (b1)
  );

  mul_iter #(.WIDTH(32), .BITS_PER_CYCLE(4)) u4 (
    .clk   (clk),
    .reset (reset),
    .bus   (b4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic go1(input logic sg, input logic ac,
                     input logic [31:0] av, input logic [31:0] bv);
    b1.is_signed = sg;
    b1.acc_en    = ac;
    b1.a         = av;
    b1.b         = bv;
    b1.start     = 1'b1;
    @(posedge clk);
    #1;
    b1.start = 1'b0;
  endtask

  task automatic go4(input logic sg, input logic ac,
                     input logic [31:0] av, input logic [31:0] bv);
    b4.is_signed = sg;
    b4.acc_en    = ac;
    b4.a         = av;
    b4.b         = bv;
    b4.start     = 1'b1;
    @(posedge clk);
    #1;
    b4.start = 1'b0;
  endtask

  // Edges after E0 until done is seen; bc counts samples with busy high.
  task automatic waitd(input bit sel, input int budget,
                       output int n, output int bc);
    logic d;
    n  = 0;
    bc = 0;
    d  = 1'b0;
    while (!d && n < budget) begin
      @(posedge clk);
      #1;
      n++;
      d = sel ? b4.done : b1.done;
      if (sel ? b4.busy : b1.busy) bc++;
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b0;
    {b1.start, b1.is_signed, b1.acc_en, b1.cancel} = '0;
    {b4.start, b4.is_signed, b4.acc_en, b4.cancel} = '0;
    b1.a = '0; b1.b = '0;
    b4.a = '0; b4.b = '0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_z1", b1.z, 64'h0);
    chk("rst_busy1", {63'h0, b1.busy}, 64'h0);
    chk("rst_done1", {63'h0, b1.done}, 64'h0);
    chk("rst_z4", b4.z, 64'h0);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // 7 * -3 signed
    go1(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD);
    chk("t1_busy_e0", {63'h0, b1.busy}, 64'h1);
    waitd(1'b0, 40, cyc, bcnt);
    chk("t1_latency", 64'(cyc), 64'd33);
    chk("t1_busy_run", 64'(bcnt), 64'd32);
    chk("t1_z", b1.z, 64'hFFFF_FFFF_FFFF_FFEB);
    chk("t1_busy_end", {63'h0, b1.busy}, 64'h0);

    // back-to-back MADD: -21 + 25
    go1(1'b1, 1'b1, 32'd5, 32'd5);
    chk("t4_done_drop", {63'h0, b1.done}, 64'h0);
    chk("t4_busy", {63'h0, b1.busy}, 64'h1);
    waitd(1'b0, 40, cyc, bcnt);
    chk("t4_latency", 64'(cyc), 64'd33);
    chk("t4_z", b1.z, 64'h0000_0000_0000_0004);
    @(posedge clk);
    #1;
    chk("t4_done_pulse", {63'h0, b1.done}, 64'h0);
    chk("t4_z_hold", b1.z, 64'h0000_0000_0000_0004);

    go1(1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    waitd(1'b0, 40, cyc, bcnt);
    chk("t2_unsigned", b1.z, 64'hFFFF_FFFE_0000_0001);
    go1(1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    waitd(1'b0, 40, cyc, bcnt);
    chk("t2_signed", b1.z, 64'h0000_0000_0000_0001);

    go1(1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000);
    waitd(1'b0, 40, cyc, bcnt);
    chk("t3_minmin", b1.z, 64'h4000_0000_0000_0000);
    go1(1'b1, 1'b0, 32'h8000_0000, 32'h0000_0001);
    waitd(1'b0, 40, cyc, bcnt);
    chk("t3_minone", b1.z, 64'hFFFF_FFFF_8000_0000);

    // start while busy at cycle 10, cancel at cycle 20
    go1(1'b0, 1'b0, 32'd3, 32'd4);
    repeat (9) @(posedge clk);
    #1;
    b1.a     = 32'd9;
    b1.start = 1'b1;
    @(posedge clk);
    #1;
    b1.start = 1'b0;
    chk("t5_busy_ignored", {63'h0, b1.busy}, 64'h1);
    repeat (9) @(posedge clk);
    #1;
    b1.cancel = 1'b1;
    @(posedge clk);
    #1;
    b1.cancel = 1'b0;
    chk("t5_cancel_busy", {63'h0, b1.busy}, 64'h0);
    chk("t5_cancel_done", {63'h0, b1.done}, 64'h0);
    dcnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (b1.done) dcnt++;
    end
    chk("t5_no_done", 64'(dcnt), 64'd0);
    chk("t5_z_kept", b1.z, 64'hFFFF_FFFF_8000_0000);

    b1.start  = 1'b1;
    b1.cancel = 1'b1;
    @(posedge clk);
    #1;
    b1.start  = 1'b0;
    b1.cancel = 1'b0;
    chk("t5_idle_cancel", {63'h0, b1.busy}, 64'h0);

    go1(1'b0, 1'b0, 32'd3, 32'd4);
    waitd(1'b0, 40, cyc, bcnt);
    chk("t5_fresh_lat", 64'(cyc), 64'd33);
    chk("t5_fresh_z", b1.z, 64'h0000_0000_0000_000C);

    // four bits per cycle
    go4(1'b0, 1'b0, 32'h1234_5678, 32'h9ABC_DEF0);
    waitd(1'b1, 20, cyc, bcnt);
    chk("t6_latency", 64'(cyc), 64'd9);
    chk("t6_z", b4.z, 64'h0B00_EA4E_242D_2080);
    go4(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD);
    waitd(1'b1, 20, cyc, bcnt);
    chk("t6_signed", b4.z, 64'hFFFF_FFFF_FFFF_FFEB);

    go4(1'b0, 1'b0, 32'd3, 32'd4);
    repeat (3) @(posedge clk);
    #1;
    chk("t6_busy_mid", {63'h0, b4.busy}, 64'h1);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("t6_rst_z", b4.z, 64'h0);
    chk("t6_rst_busy", {63'h0, b4.busy}, 64'h0);
    chk("t6_rst_done", {63'h0, b4.done}, 64'h0);
    reset = 1'b1;
    @(posedge clk);
    #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
